hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard.sv | 106 ++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard control unit for the 5-stage pipeline: tracks EX/MEM occupants to
// generate load-use and ID-branch stalls, multi-cycle load freezes and IF flush.
module hazard_scoreboard #(
  parameter int AW           = 5,
  parameter int MEM_LAT      = 0,
  parameter int BRANCH_IN_ID = 1,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [AW-1:0] id_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_is_branch,
  input  logic          branch_taken,
  input  logic          stat_clr,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          idex_bubble,
  output logic          if_flush,
  output logic          freeze,
  output logic [CW-1:0] stall_cycles
);

  localparam logic       branchInId = (BRANCH_IN_ID != 0);
  localparam logic [2:0] memLat     = 3'(MEM_LAT);

  logic          exV, exWr, exLd;
  logic [AW-1:0] exDst;
  logic          memV, memWr, memLd;
  logic [AW-1:0] memDst;
  logic [2:0]    memWcnt;
  logic [CW-1:0] stallCnt;

  logic exMatch, memMatch, loadUse, brHaz, frz, stall;

  function automatic logic srcMatch(input logic v, input logic wr, input logic [AW-1:0] d,
                                    input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                    input logic useRs, input logic useRt);
    return v && wr && (d != '0) && ((useRs && (d == rs)) || (useRt && (d == rt)));
  endfunction

  assign exMatch  = id_valid && srcMatch(exV, exWr, exDst, id_rs, id_rt, id_use_rs, id_use_rt);
  assign memMatch = id_valid && srcMatch(memV, memWr, memDst, id_rs, id_rt, id_use_rs, id_use_rt);
  assign loadUse  = exLd && exMatch;
  assign brHaz    = branchInId && id_is_branch && (exMatch || (memLd && memMatch));
  assign frz      = memV && memLd && (memWcnt != '0);
  assign stall    = !frz && (loadUse || brHaz);

  // Freeze outranks stall; flush only fires once nothing holds the front end.
  assign freeze       = frz;
  assign pc_write     = !frz && !stall;
  assign ifid_write   = !frz && !stall;
  assign idex_bubble  = stall;
  assign if_flush     = !frz && !stall && branchInId && id_valid && id_is_branch && branch_taken;
  assign stall_cycles = stallCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exV     <= 1'b0;
      exWr    <= 1'b0;
      exLd    <= 1'b0;
      exDst   <= '0;
      memV    <= 1'b0;
      memWr   <= 1'b0;
      memLd   <= 1'b0;
      memDst  <= '0;
      memWcnt <= '0;
    end else if (frz) begin
      memWcnt <= memWcnt - 3'd1;
    end else begin
      memV    <= exV;
      memWr   <= exWr;
      memLd   <= exLd;
      memDst  <= exDst;
      memWcnt <= exLd ? memLat : '0;
      if (stall || !id_valid) begin
        exV   <= 1'b0;
        exWr  <= 1'b0;
        exLd  <= 1'b0;
        exDst <= '0;
      end else begin
        exV   <= 1'b1;
        exWr  <= id_reg_write;
        exLd  <= id_mem_read;
        exDst <= id_dst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (stat_clr) begin
      stallCnt <= '0;
    end else if ((stall || frz) && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

endmodule
